// File: rtl/mouse_cursor_if.sv
// Packet-side bundle from the mouse packet stage into mouse_cursor.
// Valid/ready: no ready; xm/ym/btnm are valid only in the cycle m_done_tick is high, and the consumer always accepts.
interface mouse_cursor_if;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic       dc_state;      // double-click FSM: 0 = IDLE, 1 = WAIT

  modport master (output xm, ym, btnm, m_done_tick, input dc_state);
  modport slave  (input xm, ym, btnm, m_done_tick, output dc_state);
endinterface

// File: rtl/mouse_cursor.sv
// Absolute cursor tracker: integrates clamped mouse deltas, registers buttons,
// emits per-button edge pulses and a left-button double-click pulse.
module mouse_cursor #(
  parameter int H_MAX    = 640,
  parameter int V_MAX    = 480,
  parameter int DCLK_CYC = 25_000_000,
  parameter int SHIFT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  mouse_cursor_if.slave        pkt,
  output logic [9:0]           cursor_x,
  output logic [8:0]           cursor_y,
  output logic [2:0]           btn,
  output logic [2:0]           press,
  output logic [2:0]           rel,       // release pulses; "release" is a reserved word
  output logic                 dbl_click,
  output logic                 upd_tick
);

  localparam int CW = $clog2(DCLK_CYC + 1);
  localparam logic [CW-1:0]     DC_LOAD = CW'(DCLK_CYC);
  localparam logic signed [11:0] X_LIM  = 12'(H_MAX - 1);
  localparam logic signed [11:0] Y_LIM  = 12'(V_MAX - 1);
  localparam logic [9:0]        X_CTR   = 10'(H_MAX / 2);
  localparam logic [8:0]        Y_CTR   = 9'(V_MAX / 2);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} dc_state_t;

  dc_state_t      state, state_n;
  logic [CW-1:0]  dc_cnt, dc_cnt_n;
  logic           dbl_n;

  logic signed [11:0] xs, ys, dx, dy, nx, ny;
  logic [9:0]         x_clamped;
  logic [8:0]         y_clamped;
  logic               left_press;

  // Deltas are sign-extended before the arithmetic shift, so negatives round toward -inf.
  always_comb begin
    xs = {{3{pkt.xm[8]}}, pkt.xm};
    ys = {{3{pkt.ym[8]}}, pkt.ym};
    dx = xs >>> SHIFT;
    dy = ys >>> SHIFT;
    nx = $signed({2'b00, cursor_x}) + dx;
    ny = $signed({3'b000, cursor_y}) - dy;
    if (nx < 0)          x_clamped = '0;
    else if (nx > X_LIM) x_clamped = X_LIM[9:0];
    else                 x_clamped = nx[9:0];
    if (ny < 0)          y_clamped = '0;
    else if (ny > Y_LIM) y_clamped = Y_LIM[8:0];
    else                 y_clamped = ny[8:0];
  end

  assign left_press   = pkt.m_done_tick & pkt.btnm[0] & ~btn[0];
  assign pkt.dc_state = (state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_x <= X_CTR;
      cursor_y <= Y_CTR;
      btn      <= '0;
      press    <= '0;
      rel      <= '0;
      upd_tick <= 1'b0;
    end else begin
      press    <= '0;
      rel      <= '0;
      upd_tick <= pkt.m_done_tick | clr;
      if (pkt.m_done_tick) begin
        btn   <= pkt.btnm;
        press <= pkt.btnm & ~btn;
        rel   <= ~pkt.btnm & btn;
      end
      // Recenter overrides any movement carried by a coincident packet.
      if (clr) begin
        cursor_x <= X_CTR;
        cursor_y <= Y_CTR;
      end else if (pkt.m_done_tick) begin
        cursor_x <= x_clamped;
        cursor_y <= y_clamped;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dc_cnt    <= '0;
      dbl_click <= 1'b0;
    end else begin
      state     <= state_n;
      dc_cnt    <= dc_cnt_n;
      dbl_click <= dbl_n;
    end
  end

  always_comb begin
    state_n  = state;
    dc_cnt_n = dc_cnt;
    dbl_n    = 1'b0;
    case (state)
      IDLE: begin
        if (left_press) begin
          state_n  = WAIT;
          dc_cnt_n = DC_LOAD;
        end
      end
      WAIT: begin
        // A press landing exactly on expiry counts as a fresh first click.
        if (dc_cnt == '0) begin
          if (left_press) begin
            state_n  = WAIT;
            dc_cnt_n = DC_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else if (left_press) begin
          dbl_n    = 1'b1;
          state_n  = IDLE;
          dc_cnt_n = '0;
        end else begin
          dc_cnt_n = dc_cnt - CW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        dc_cnt_n = '0;
      end
    endcase
  end

endmodule
